// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder. start is a request: it is taken on
// any rising edge where the adder is not busy; done pulses once with sum/cout valid.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two cascaded half-adder stages.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  assign s1 = x ^ y;
  assign c1 = x & y;
  assign s  = s1 ^ cin;
  assign c2 = s1 & cin;
  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder_core.sv
// Control FSM and shift-register datapath; one full-adder bit processed per clock.
module serial_adder_core
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_nxt;
  logic               busy_q;
  logic               done_q;
  logic               busy_nxt;
  logic               done_nxt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               last_shift;
  logic               fa_s;
  logic               fa_co;

  assign accept     = bus.start && (state != SHIFT);
  assign last_shift = (state == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

  // State register; busy/done are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = (state_nxt == SHIFT);
    done_nxt = (state_nxt == DONE);
  end

  full_adder_bit u_fa (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // sum/cout are only written by shifts, so they keep the last result across an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (state == SHIFT) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
      carry_q <= fa_co;
      cout_q  <= fa_co;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder top: flat ports bundled onto the internal request/result interface.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  assign bus.start = start;
  assign bus.a     = a;
  assign bus.b     = b;
  assign busy      = bus.busy;
  assign done      = bus.done;
  assign sum       = bus.sum;
  assign cout      = bus.cout;

  serial_adder_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port sum, output, WIDTH bits: the result bits of a+b.
REQ-010 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE.
REQ-013 On acceptance: latch a and b into shift registers; clear the carry flip-flop and the bit counter; go to SHIFT.
REQ-014 Each clock edge in SHIFT SHALL add bit 0 of both shift registers and the carry flip-flop through one full-adder bit.
REQ-015 On the same edge, the sum bit SHALL shift into sum from the MSB end (sum shifts right), the carry flip-flop SHALL update, both operand registers SHALL shift right, and the counter SHALL increment.
REQ-016 The result SHALL be produced LSB first: after WIDTH shifts, sum holds (a+b) mod 2^WIDTH and cout holds bit WIDTH.
REQ-017 Latency: with start accepted on edge 0, shifts SHALL occur on edges 1..WIDTH; the FSM SHALL enter DONE on edge WIDTH and return to IDLE on edge WIDTH+1 unless a new start is accepted.
REQ-018 done SHALL be high exactly while in DONE; busy SHALL be high exactly while in SHIFT.
REQ-019 done and busy SHALL be registered and never high together.
REQ-020 start while in SHIFT SHALL be ignored with no effect on state, operands or counter.
REQ-021 start in DONE SHALL be accepted, giving back-to-back operation with done high for one cycle.
REQ-022 sum and cout SHALL hold their final values from entry to DONE until the first shift of the next operation.
REQ-023 The counter SHALL be $clog2(WIDTH+1) bits; the exit compare SHALL be count==WIDTH-1 on the final shift, with no wrap.
REQ-024 Operand changes on a or b after acceptance SHALL NOT affect the result.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, and clear busy, done, sum, cout, the carry flip-flop, the counter and both operand registers.
REQ-026 Reset asserted mid-operation SHALL abort the addition without producing done.
REQ-027 After rst_n deasserts, the block SHALL accept start on the first clock edge.

Structure
REQ-028 A shared package serial_adder_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and the default-width constant.
REQ-029 The per-bit add SHALL be one sub-module, full_adder_bit (inputs x, y, cin; outputs s, co), built as two cascaded half-adder stages ORed for carry.
REQ-030 The datapath SHALL be exactly one full_adder_bit instance plus shift registers, with no parallel adder.

Verification
REQ-031 WIDTH=8, a=0x00, b=0x00, start -> done on edge 8 only; sum=0x00, cout=0.
REQ-032 a=0xFF, b=0x01 -> sum=0x00, cout=1; busy high for 8 cycles exactly.
REQ-033 a=0xA5, b=0x5A -> sum=0xFF, cout=0; a and b changed to 0x00 during SHIFT, result unchanged.
REQ-034 start a=0x0F, b=0x01; a second start with 0xFF/0xFF pulsed at edge 3 -> second start ignored; sum=0x10, cout=0.
REQ-035 rst_n pulsed low at edge 4 of an operation -> outputs zero immediately, no done; a fresh start of 0x80+0x80 -> sum=0x00, cout=1.
REQ-036 start held high continuously with 0x01+0x02 then 0x03+0x04 -> done pulses 9 cycles apart; results 0x03, then 0x07.
